// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory-request inputs and stage enable/flush outputs of pipeline_ctrl.
// slave = the sequencer, master = the pipeline driving the hazard flags.
interface pipeline_ctrl_if;
  logic        LoadSlot;
  logic        BranchSlot;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [15:0] MEM_Addr;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IDEX_Write;
  logic        EXMEM_Write;
  logic        MEMWB_Write;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        EXMEM_Flush;
  logic        MEMWB_Flush;
  logic        RamOwner;
  logic        Stealing;

  modport master (
    output LoadSlot,
    output BranchSlot,
    output MEM_MemRead,
    output MEM_MemWrite,
    output MEM_Addr,
    input  PC_Write,
    input  IFID_Write,
    input  IDEX_Write,
    input  EXMEM_Write,
    input  MEMWB_Write,
    input  IFID_Flush,
    input  IDEX_Flush,
    input  EXMEM_Flush,
    input  MEMWB_Flush,
    input  RamOwner,
    input  Stealing
  );

  modport slave (
    input  LoadSlot,
    input  BranchSlot,
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  MEM_Addr,
    output PC_Write,
    output IFID_Write,
    output IDEX_Write,
    output EXMEM_Write,
    output MEMWB_Write,
    output IFID_Flush,
    output IDEX_Flush,
    output EXMEM_Flush,
    output MEMWB_Flush,
    output RamOwner,
    output Stealing
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer with instruction-RAM steal arbitration.
// Optional perf counters: define PIPECTRL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PIPECTRL_PERF_CNT_EN
  output logic [15:0] LoadStallCnt,
  output logic [15:0] StealCycleCnt,
  output logic [15:0] BranchFlushCnt,
`endif
  pipeline_ctrl_if.slave ctl
);

  typedef enum logic {
    RUN   = 1'b0,
    STEAL = 1'b1
  } state_e;

  localparam logic [3:0] LAST  = 4'(MEM_WAIT - 1);
  localparam bit         MULTI = (MEM_WAIT >= 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic conflict;
  logic freeze;
  logic fin;
  logic run_free;
  logic br_run;
  logic ld_run;

  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w;
  logic ifid_f, idex_f, exmem_f, memwb_f;
  logic ram_own;

  // Instruction space is the lower half of the address map.
  assign conflict = (ctl.MEM_MemRead | ctl.MEM_MemWrite)
                  & ~ctl.MEM_Addr[15];

  always_comb begin
    freeze = 1'b0;
    fin    = 1'b0;
    if (state_q == STEAL) begin
      if (cnt_q < LAST) freeze = 1'b1;
      else              fin    = 1'b1;
    end else if (conflict) begin
      if (MULTI) freeze = 1'b1;
      else       fin    = 1'b1;
    end
  end

  assign run_free = ~rst & (state_q == RUN) & ~conflict;
  assign br_run   = run_free & ctl.BranchSlot;
  assign ld_run   = run_free & ctl.LoadSlot & ~ctl.BranchSlot;

  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    exmem_w = 1'b1;
    memwb_w = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    exmem_f = 1'b0;
    memwb_f = 1'b0;
    ram_own = 1'b0;
    state_d = RUN;
    cnt_d   = 4'd0;
    if (rst) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_w = 1'b0;
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
      exmem_f = 1'b1;
      memwb_f = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          ram_own = 1'b1;
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          exmem_w = 1'b0;
          memwb_f = 1'b1;
          state_d = STEAL;
          cnt_d   = cnt_q + 4'd1;
        end
        fin: begin
          // Fetch was stolen, so the PC holds and the fetch repeats.
          ram_own = 1'b1;
          pc_w    = 1'b0;
          if (ctl.LoadSlot) begin
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end else begin
            ifid_f = 1'b1;
          end
        end
        br_run: begin
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          exmem_f = 1'b1;
        end
        ld_run: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctl.PC_Write    = pc_w;
  assign ctl.IFID_Write  = ifid_w;
  assign ctl.IDEX_Write  = idex_w;
  assign ctl.EXMEM_Write = exmem_w;
  assign ctl.MEMWB_Write = memwb_w;
  assign ctl.IFID_Flush  = ifid_f;
  assign ctl.IDEX_Flush  = idex_f;
  assign ctl.EXMEM_Flush = exmem_f;
  assign ctl.MEMWB_Flush = memwb_f;
  assign ctl.RamOwner    = ram_own;
  assign ctl.Stealing    = ~rst & (state_q == STEAL);

`ifdef PIPECTRL_PERF_CNT_EN
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic [15:0] st_cnt_q, st_cnt_d;
  logic [15:0] br_cnt_q, br_cnt_d;

  // Saturating counters: they stick at all-ones.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    br_cnt_d = br_cnt_q;
    if (ld_run && ld_cnt_q != 16'hFFFF)
      ld_cnt_d = ld_cnt_q + 16'd1;
    if (ram_own && st_cnt_q != 16'hFFFF)
      st_cnt_d = st_cnt_q + 16'd1;
    if (br_run && br_cnt_q != 16'hFFFF)
      br_cnt_d = br_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= 16'd0;
      st_cnt_q <= 16'd0;
      br_cnt_q <= 16'd0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  assign LoadStallCnt   = ld_cnt_q;
  assign StealCycleCnt  = st_cnt_q;
  assign BranchFlushCnt = br_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MEM_WAIT=3) against a reference model.
// Perf-counter checks are active when PIPECTRL_PERF_CNT_EN is defined.
module tb_pipeline_ctrl;
  localparam int MW = 3;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  pipeline_ctrl_if ctl_if ();

`ifdef PIPECTRL_PERF_CNT_EN
  logic [15:0] ld_cnt, st_cnt, br_cnt;
  int m_ld, m_st, m_br;
`endif

  pipeline_ctrl #(.MEM_WAIT(MW)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef PIPECTRL_PERF_CNT_EN
    .LoadStallCnt  (ld_cnt),
    .StealCycleCnt (st_cnt),
    .BranchFlushCnt(br_cnt),
`endif
    .ctl           (ctl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of steal cycles already spent on the current MEM access.
  int pos;

  // {PC,IFID,IDEX,EXMEM,MEMWB writes, IFID,IDEX,EXMEM,MEMWB flushes, RamOwner, Stealing}
  function automatic logic [10:0] model(
    input logic r, input logic ls, input logic bs,
    input logic conf, input int p);
    logic [4:0] w;
    logic [3:0] f;
    logic       own;
    logic       stl;
    if (r) return {5'b00000, 4'b1111, 2'b00};
    w = 5'b11111;
    f = 4'b0000;
    own = 1'b0;
    stl = (p > 0);
    if (p > 0 || conf) begin
      own = 1'b1;
      if (p + 1 < MW) begin
        w = 5'b00001;
        f = 4'b0001;
      end else begin
        w = ls ? 5'b00111 : 5'b01111;
        f = ls ? 4'b0100 : 4'b1000;
      end
    end else if (bs) begin
      f = 4'b1110;
    end else if (ls) begin
      w = 5'b00111;
      f = 4'b0100;
    end
    return {w, f, own, stl};
  endfunction

  task automatic step(
    input logic r, input logic ls, input logic bs,
    input logic rd, input logic wr, input logic [15:0] a,
    input string tag);
    logic        conf;
    logic [10:0] exp_v;
    logic [10:0] obs;
    @(negedge clk);
    rst                 = r;
    ctl_if.LoadSlot     = ls;
    ctl_if.BranchSlot   = bs;
    ctl_if.MEM_MemRead  = rd;
    ctl_if.MEM_MemWrite = wr;
    ctl_if.MEM_Addr     = a;
    #1;
    conf  = (rd | wr) && (a < 16'h8000);
    exp_v = model(r, ls, bs, conf, pos);
    obs = {ctl_if.PC_Write, ctl_if.IFID_Write, ctl_if.IDEX_Write,
           ctl_if.EXMEM_Write, ctl_if.MEMWB_Write,
           ctl_if.IFID_Flush, ctl_if.IDEX_Flush,
           ctl_if.EXMEM_Flush, ctl_if.MEMWB_Flush,
           ctl_if.RamOwner, ctl_if.Stealing};
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp_v);
    end
`ifdef PIPECTRL_PERF_CNT_EN
    compared++;
    assert ({ld_cnt, st_cnt, br_cnt} === {16'(m_ld), 16'(m_st), 16'(m_br)})
    else begin
      mismatched++;
      $error("FAIL %s perf observed=%h/%h/%h expected=%h/%h/%h",
             tag, ld_cnt, st_cnt, br_cnt, m_ld, m_st, m_br);
    end
`endif
    @(posedge clk);
`ifdef PIPECTRL_PERF_CNT_EN
    if (r) begin
      m_ld = 0;
      m_st = 0;
      m_br = 0;
    end else begin
      if (exp_v[1] && m_st < 65535) m_st++;
      if (!(pos > 0 || conf) && bs && m_br < 65535) m_br++;
      if (!(pos > 0 || conf) && ls && !bs && m_ld < 65535) m_ld++;
    end
`endif
    if (r) pos = 0;
    else if (pos > 0 || conf) pos = (pos + 1 < MW) ? pos + 1 : 0;
    else pos = 0;
  endtask

  initial begin
    logic       r, ls, bs, rd, wr;
    logic [15:0] a;
    compared   = 0;
    mismatched = 0;
    pos        = 0;
`ifdef PIPECTRL_PERF_CNT_EN
    m_ld = 0;
    m_st = 0;
    m_br = 0;
`endif
    rst                 = 1'b1;
    ctl_if.LoadSlot     = 1'b0;
    ctl_if.BranchSlot   = 1'b0;
    ctl_if.MEM_MemRead  = 1'b0;
    ctl_if.MEM_MemWrite = 1'b0;
    ctl_if.MEM_Addr     = 16'h0000;

    step(1, 0, 0, 0, 0, 16'h0000, "reset1");
    step(1, 0, 0, 0, 0, 16'h0000, "reset2");
    step(0, 0, 0, 0, 0, 16'h0000, "idle");
    step(0, 1, 0, 0, 0, 16'h0000, "load_use");
    step(0, 1, 0, 0, 0, 16'h9000, "load_use_dread");
    step(0, 1, 1, 0, 0, 16'h0000, "branch_prio");
    step(0, 0, 1, 0, 0, 16'h0000, "branch");
    step(0, 0, 0, 0, 1, 16'h4000, "steal_c1");
    step(0, 0, 0, 0, 1, 16'h4000, "steal_c2");
    step(0, 0, 0, 0, 1, 16'h4000, "steal_c3");
    step(0, 0, 0, 0, 0, 16'h0000, "steal_after");
    step(0, 1, 0, 0, 0, 16'h0000, "ld_stall1");
    step(0, 1, 0, 0, 0, 16'h0000, "ld_stall2");
    step(0, 0, 0, 0, 1, 16'h8000, "data_space");
    step(0, 0, 0, 1, 0, 16'h7FFF, "bb_c1");
    step(0, 1, 0, 1, 0, 16'h7FFF, "bb_c2_ld_ign");
    step(0, 1, 0, 1, 0, 16'h7FFF, "bb_c3_ld");
    step(0, 0, 0, 1, 0, 16'h0010, "bb_next_c1");
    step(0, 0, 1, 1, 0, 16'h0010, "bb_next_c2");
    step(0, 0, 0, 1, 0, 16'h0010, "bb_next_c3");
    step(0, 0, 0, 0, 1, 16'h4000, "rsteal_c1");
    step(1, 0, 0, 0, 1, 16'h4000, "rsteal_rst");
    step(0, 0, 0, 0, 0, 16'h0000, "rsteal_after");

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      ls = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 4) == 0);
      wr = ($urandom_range(0, 5) == 0);
      a  = 16'($urandom);
      step(r, ls, bs, rd, wr, a, "random");
    end

`ifdef PIPECTRL_PERF_CNT_EN
    step(1, 0, 0, 0, 0, 16'h0000, "sat_reset");
    for (int i = 0; i < 65540; i++)
      step(0, 1, 0, 0, 0, 16'h0000, "sat_load");
    step(0, 0, 0, 0, 0, 16'h0000, "sat_hold");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It consumes the hazard flags LoadSlot and BranchSlot together with the MEM-stage memory request. It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also arbitrates the shared instruction RAM: a MEM-stage access to instruction space (address < 16'h8000) steals the RAM from instruction fetch for MEM_WAIT cycles, and the pipeline is frozen while that happens.

## Interface
- MEM_WAIT, 2, cycles per instruction-RAM data access; legal range 1..15.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- LoadSlot  in  1  load-use hazard flag from the hazard detection unit.
- BranchSlot  in  1  taken branch/jump resolved in MEM.
- MEM_MemRead  in  1  MEM-stage load.
- MEM_MemWrite  in  1  MEM-stage store.
- MEM_Addr  in  16  MEM-stage data address.
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1 each  register enables.
- IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  load a bubble (NOP) instead of the stage input.
- RamOwner  out  1  0 = IF owns the instruction RAM; 1 = MEM owns it.
- Stealing  out  1  high while state = STEAL.

## Operation
- Conflict = (MEM_MemRead | MEM_MemWrite) & (MEM_Addr < 16'h8000).
- State is 1 bit: RUN or STEAL. The 4-bit counter cnt counts completed steal cycles.
- All outputs are combinational from the state, cnt and the inputs. Defaults: all *_Write=1, all *_Flush=0, RamOwner=0.
- **RUN, no Conflict, BranchSlot=1:** IFID_Flush=IDEX_Flush=EXMEM_Flush=1 and PC_Write=1, so the branch target loads. LoadSlot is ignored in this case.
- **RUN, no Conflict, LoadSlot=1, BranchSlot=0:** PC_Write=0, IFID_Write=0, IDEX_Flush=1. The other stages advance.
- **Freeze cycle:** either RUN with Conflict and MEM_WAIT≥2, or STEAL with cnt<MEM_WAIT-1. Outputs:
  - RamOwner=1.
  - PC_Write, IFID_Write, IDEX_Write and EXMEM_Write all 0.
  - MEMWB_Write=1 and MEMWB_Flush=1.
  - State goes to STEAL and cnt increments.
- **Final access cycle:** either RUN with Conflict and MEM_WAIT=1, or STEAL with cnt=MEM_WAIT-1. Outputs:
  - RamOwner=1 and PC_Write=0, so the stolen fetch repeats.
  - IDEX, EXMEM and MEMWB advance.
  - If LoadSlot=1: IFID_Write=0 and IDEX_Flush=1. Otherwise IFID_Flush=1.
  - Next state is RUN and cnt resets to 0.
- BranchSlot is ignored during any Conflict or STEAL cycle. A branch never accesses memory, so this case is unreachable in legal code.
- LoadSlot is ignored in freeze cycles. It is held stable because ID/EX is frozen, and is acted on in the final access cycle.
- A Flush overrides its Write.

## Timing
- Stall and flush response is zero-latency: a hazard flag affects the same clock edge on which it is asserted.
- Steal length is exactly MEM_WAIT cycles with RamOwner=1. RamOwner returns to 0 on the cycle after the final access cycle.
- Back-to-back instruction-space accesses: a new Conflict in RUN directly after a final access cycle starts a new steal immediately, with no gap cycle.
- While rst=1, outputs are forced regardless of state:
  - all *_Write=0;
  - all *_Flush=1;
  - RamOwner=0, Stealing=0.
- Next state after rst is RUN with cnt=0. This includes rst asserted mid-STEAL, which abandons the steal.
- The inputs must be stable before the rising edge. The block has no internal synchronisers.

## Configuration
- PIPECTRL_PERF_CNT_EN defined: adds three output ports, all 16-bit saturating counters (hold at 16'hFFFF) and cleared by rst:
  - LoadStallCnt: increments on each RUN LoadSlot stall cycle.
  - StealCycleCnt: increments on each cycle with RamOwner=1.
  - BranchFlushCnt: increments on each BranchSlot flush cycle.
- PIPECTRL_PERF_CNT_EN undefined: the three ports and their logic are absent. Everything else is identical.

## Test plan
- **Reset:** rst=1 for 2 cycles → all *_Write=0, all *_Flush=1, RamOwner=0. After release with idle inputs → all *_Write=1, all *_Flush=0.
- **Load-use stall:** LoadSlot=1, no memory access → PC_Write=0, IFID_Write=0, IDEX_Flush=1, EXMEM_Write=1 in the same cycle.
- **Branch priority:** BranchSlot=1 and LoadSlot=1 together → PC_Write=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, IFID_Write unaffected by LoadSlot.
- **Steal, MEM_WAIT=3:** MEM_MemWrite=1, MEM_Addr=16'h4000 → RamOwner=1 for 3 cycles. Cycles 1–2 freeze with MEMWB_Flush=1. Cycle 3 has PC_Write=0, IFID_Flush=1, EXMEM_Write=1. Cycle 4 has RamOwner=0.
- **Data space and mid-steal reset:** MEM_Addr=16'h8000 → no steal, all enables 1. Repeat the steal from 16'h4000 and assert rst in freeze cycle 2 → next cycle Stealing=0, RamOwner=0.
- **Perf counters (PIPECTRL_PERF_CNT_EN):** after the MEM_WAIT=3 steal plus 2 LoadSlot cycles → StealCycleCnt=3, LoadStallCnt=2. Preload near saturation → the counters hold at 16'hFFFF.
